cdb_result_queue: RTL

Buffers results from a fixed-latency multi-cycle execution unit and hands them to the common data bus (CDB) arbiter under a valid/ready handshake. Sits directly downstream of the multi-cycle unit model: each cycle the unit may retire one result (tag + data), and this queue holds it until the CDB grants a broadcast slot. Results leave in strict arrival order. A flush input discards everything on a mispredict.

---
 rtl/ooo_pkg.sv | 15 +
 rtl/cdb_result_queue_if.sv | 31 +++
 rtl/cdb_rq_storage.sv | 26 ++
 rtl/cdb_result_queue.sv | 93 +++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: default tag/data widths and the result record
// (tag + data) carried from execution units towards the CDB.
package ooo_pkg;
  localparam int DEF_TAG_W = 6;
  localparam int DEF_SIZE  = 32;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_SIZE-1:0]  data;
  } result_t;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/cdb_result_queue_if.sv
// Result-queue boundary: unit-side push, CDB-side pop, flush and status.
// master = unit/CDB environment, slave = the queue itself.
interface cdb_result_queue_if #(
  parameter int SIZE  = ooo_pkg::DEF_SIZE,
  parameter int TAG_W = ooo_pkg::DEF_TAG_W,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [TAG_W-1:0] in_tag;
  logic [SIZE-1:0]  in_data;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [SIZE-1:0]  out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (
    output in_valid, in_tag, in_data, flush, out_ready,
    input  in_ready, out_valid, out_tag, out_data, count, overflow
  );

  modport slave (
    input  in_valid, in_tag, in_data, flush, out_ready,
    output in_ready, out_valid, out_tag, out_data, count, overflow
  );
endinterface

// File: rtl/cdb_rq_storage.sv
// DEPTH x W register file: one synchronous write port, one asynchronous read port,
// contents cleared asynchronously by reset. Read data valid in the same cycle.
module cdb_rq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdat,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdat
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_raddr];
endmodule

// File: rtl/cdb_result_queue.sv
// In-order result FIFO between a multi-cycle unit and the CDB; 1-cycle latency, or 0 when
// empty with CDB_RQ_BYPASS_EN. in_ready drops only when full and the CDB is not popping.
module cdb_result_queue
  import ooo_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int TAG_W = DEF_TAG_W,
  parameter int DEPTH = 4
) (
  input logic               clock,
  input logic               reset,
  cdb_result_queue_if.slave rq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int W  = TAG_W + SIZE;

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_byp;
  logic          w_wr;
  logic          w_rd;
  logic [W-1:0]  w_rd_dat;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A full queue still accepts when the head leaves in the same cycle.
  assign rq.in_ready = !w_full || rq.out_ready;
  assign w_push      = rq.in_valid && rq.in_ready;

`ifdef CDB_RQ_BYPASS_EN
  assign w_byp = w_empty && rq.in_valid && !rq.flush;
`else
  assign w_byp = 1'b0;
`endif

  assign rq.out_valid                = !w_empty || w_byp;
  assign {rq.out_tag, rq.out_data}   = w_byp ? {rq.in_tag, rq.in_data} : w_rd_dat;
  assign w_pop                       = rq.out_valid && rq.out_ready;

  // A bypassed result that is granted immediately never touches storage.
  assign w_wr = w_push && !rq.flush && !(w_byp && rq.out_ready);
  assign w_rd = w_pop && !w_byp && !rq.flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (rq.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  // Sticky integration-error flag; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (rq.in_valid && !rq.in_ready && !rq.flush) begin
      r_overflow <= 1'b1;
    end
  end

  assign rq.count    = r_count;
  assign rq.overflow = r_overflow;

  cdb_rq_storage #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_storage (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdat  ({rq.in_tag, rq.in_data}),
    .i_raddr (r_rd_ptr),
    .o_rdat  (w_rd_dat)
  );
endmodule
